chan_mux_scan: RTL and testbench

Parametrised, registered N-channel data selector for board-level test and display paths: the next generation of the 4:1 switch-to-LED multiplexer. It adds configurable channel count and width, registered outputs, a per-channel enable mask, and three sequential selection modes beyond direct selection: timed auto-scan, single-step on a button edge, and freeze. It sits between switch/peripheral data sources and LED, 7-segment or LCD consumers.

---
 rtl/chan_mux_pkg.sv | 13 +
 rtl/chan_next_enabled.sv | 30 +++
 rtl/chan_mux_scan.sv | 97 +++++++++
 tb/tb_chan_mux_scan.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer/scanner.
package chan_mux_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_STEP   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

endpackage

// File: rtl/chan_next_enabled.sv
// Finds the next enabled channel after cur, wrapping, with cur itself examined last.
module chan_next_enabled #(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SELW = $clog2(CHANNELS)
) (
  input  logic [SELW-1:0]     cur,
  input  logic [CHANNELS-1:0] mask,
  output logic [SELW-1:0]     nxt,
  output logic                any_en
);

  logic [CHANNELS-1:0] rot;
  logic [SELW-1:0]     off;

  // Rotate so that bit 0 is the channel right after cur, then pick the lowest set bit.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      rot[i] = mask[SELW'((32'(cur) + 32'(i) + 32'd1) % CHANNELS)];
    end
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
  end

  assign any_en = |mask;
  assign nxt    = any_en ? SELW'((32'(cur) + 32'(off) + 32'd1) % CHANNELS) : cur;

endmodule

// File: rtl/chan_mux_scan.sv
// Registered N:1 channel selector with manual, timed auto-scan, single-step and hold modes.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DWELL    = 50_000_000,
  localparam int unsigned SELW    = $clog2(CHANNELS)
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [CHANNELS*WIDTH-1:0] iDATA,
  input  logic [CHANNELS-1:0]       iMASK,
  input  logic [MODE_W-1:0]         iMODE,
  input  logic [SELW-1:0]           iSEL,
  input  logic                      iSTEP,
  output logic [WIDTH-1:0]          oDATA,
  output logic [SELW-1:0]           oSEL,
  output logic                      oSTROBE,
  output logic                      oNONE
);

  localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  mode_e           mode;
  mode_e           mode_q;
  logic            mode_chg;
  logic            step_q;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_eff;
  logic [CNTW-1:0] cnt_next;
  logic [SELW-1:0] nxt_sel;
  logic [SELW-1:0] next_sel;
  logic            any_en;

  assign mode     = mode_e'(iMODE);
  assign mode_chg = (mode != mode_q);

  chan_next_enabled #(
    .CHANNELS (CHANNELS)
  ) u_next (
    .cur    (oSEL),
    .mask   (iMASK),
    .nxt    (nxt_sel),
    .any_en (any_en)
  );

  // Next index and dwell counter; a mode change makes this edge count as dwell cycle 0.
  always_comb begin
    next_sel = oSEL;
    cnt_eff  = mode_chg ? '0 : cnt;
    cnt_next = cnt;
    case (mode)
      MODE_MANUAL: begin
        cnt_next = '0;
        if (32'(iSEL) < CHANNELS) next_sel = iSEL;
      end
      MODE_SCAN: begin
        if (!iMASK[oSEL] || (cnt_eff == CNTW'(DWELL - 1))) begin
          next_sel = nxt_sel;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_eff + 1'b1;
        end
      end
      MODE_STEP: begin
        cnt_next = '0;
        if (iSTEP && !step_q) next_sel = nxt_sel;
      end
      default: begin
        // hold: selection and counter frozen
        cnt_next = cnt_eff;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_q  <= MODE_MANUAL;
      step_q  <= 1'b0;
      cnt     <= '0;
      oSEL    <= '0;
      oDATA   <= '0;
      oSTROBE <= 1'b0;
      oNONE   <= 1'b0;
    end else begin
      mode_q  <= mode;
      step_q  <= iSTEP;
      cnt     <= cnt_next;
      oSEL    <= next_sel;
      oSTROBE <= (next_sel != oSEL);
      oNONE   <= !any_en && ((mode == MODE_SCAN) || (mode == MODE_STEP));
      if (mode != MODE_HOLD) oDATA <= iDATA[int'(next_sel)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan with CHANNELS=4, WIDTH=4, DWELL=3.
module tb_chan_mux_scan;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned DWELL    = 3;
  localparam logic [15:0] DATA0    = {4'hD, 4'hC, 4'hB, 4'hA};

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [15:0] iDATA;
  logic [3:0]  iMASK;
  logic [1:0]  iMODE;
  logic [1:0]  iSEL;
  logic        iSTEP;
  logic [3:0]  oDATA;
  logic [1:0]  oSEL;
  logic        oSTROBE;
  logic        oNONE;

  int errors = 0;
  int checks = 0;

  chan_mux_scan #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .DWELL    (DWELL)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iMASK   (iMASK),
    .iMODE   (iMODE),
    .iSEL    (iSEL),
    .iSTEP   (iSTEP),
    .oDATA   (oDATA),
    .oSEL    (oSEL),
    .oSTROBE (oSTROBE),
    .oNONE   (oNONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks selection, data and strobe together.
  task automatic check_out(input string tag, input logic [1:0] sel, input logic [3:0] data,
                           input logic strobe);
    check({tag, ".sel"}, 32'(oSEL), 32'(sel));
    check({tag, ".data"}, 32'(oDATA), 32'(data));
    check({tag, ".strobe"}, 32'(oSTROBE), 32'(strobe));
  endtask

  initial begin
    logic [1:0] seq4 [4];
    logic [3:0] dat4 [4];
    logic [1:0] seq3 [3];
    logic [3:0] dat3 [3];
    seq4 = '{2'd1, 2'd2, 2'd3, 2'd0};
    dat4 = '{4'hB, 4'hC, 4'hD, 4'hA};
    seq3 = '{2'd3, 2'd1, 2'd3};
    dat3 = '{4'hD, 4'hB, 4'hD};

    iRST  = 1'b1;
    iDATA = DATA0;
    iMASK = 4'b1111;
    iMODE = 2'b00;
    iSEL  = 2'd0;
    iSTEP = 1'b0;
    #2;
    check_out("reset", 2'd0, 4'h0, 1'b0);
    check("reset.none", 32'(oNONE), 32'd0);
    tick();
    tick();
    iRST = 1'b0;

    // Manual selection
    tick();
    check_out("man_sel0", 2'd0, 4'hA, 1'b0);
    iSEL = 2'd2;
    tick();
    check_out("man_sel2", 2'd2, 4'hC, 1'b1);
    tick();
    check_out("man_sel2_hold", 2'd2, 4'hC, 1'b0);
    iDATA = {4'hD, 4'h5, 4'hB, 4'hA};
    tick();
    check("man_data_track", 32'(oDATA), 32'h5);
    iDATA = DATA0;
    iSEL  = 2'd0;
    tick();
    check_out("man_back0", 2'd0, 4'hA, 1'b1);

    // Auto-scan, full mask
    iMODE = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      check("scan_full_dwell", 32'(oSTROBE), 32'd0);
      tick();
      check_out("scan_full_adv", seq4[k], dat4[k], 1'b1);
    end

    // Auto-scan with mask 1010: channel 0 disabled, leave at once
    iMASK = 4'b1010;
    tick();
    check_out("scan_skip0", 2'd1, 4'hB, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
      check("scan_alt_dwell", 32'(oSEL), (k == 1) ? 32'd3 : 32'd1);
      tick();
      check_out("scan_alt_adv", seq3[k], dat3[k], 1'b1);
    end
    tick();
    iMASK = 4'b0010;
    tick();
    check_out("scan_unmask3", 2'd1, 4'hB, 1'b1);

    // Empty mask in scan: stable, oNONE set, data still tracks
    iMASK = 4'b0000;
    iDATA = {4'hD, 4'hC, 4'h7, 4'hA};
    tick();
    check("scan_none", 32'(oNONE), 32'd1);
    check_out("scan_none_out", 2'd1, 4'h7, 1'b0);
    tick();
    check("scan_none_stable", 32'(oSEL), 32'd1);
    iDATA = DATA0;

    // Step mode: held level gives one step
    iMASK = 4'b1111;
    iMODE = 2'b10;
    tick();
    check("step_none_clr", 32'(oNONE), 32'd0);
    check_out("step_enter", 2'd1, 4'hB, 1'b0);
    iSTEP = 1'b1;
    tick();
    check_out("step_hold_first", 2'd2, 4'hC, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    check_out("step_hold_one", 2'd2, 4'hC, 1'b0);
    iSTEP = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      iSTEP = 1'b1;
      tick();
      check_out("step_pulse", 2'((3 + k) % 4), dat4[(2 + k) % 4], 1'b1);
      iSTEP = 1'b0;
      tick();
    end
    iMASK = 4'b0000;
    tick();
    check("step_none", 32'(oNONE), 32'd1);

    // Hold: selection and data frozen, step ignored
    iMASK = 4'b1111;
    iMODE = 2'b11;
    tick();
    check("hold_none", 32'(oNONE), 32'd0);
    iDATA = 16'h1234;
    iSTEP = 1'b1;
    tick();
    check_out("hold_frozen", 2'd1, 4'hB, 1'b0);
    iSTEP = 1'b0;
    tick();
    check_out("hold_frozen2", 2'd1, 4'hB, 1'b0);
    iDATA = DATA0;

    // Reset mid-dwell, no clock edge
    iMODE = 2'b01;
    tick();
    tick();
    check("pre_reset_sel", 32'(oSEL), 32'd1);
    iRST = 1'b1;
    #1;
    check_out("async_reset", 2'd0, 4'h0, 1'b0);
    check("async_reset.none", 32'(oNONE), 32'd0);
    #2;
    iRST = 1'b0;
    tick();
    check_out("post_reset_e1", 2'd0, 4'hA, 1'b0);
    tick();
    check("post_reset_e2", 32'(oSEL), 32'd0);
    tick();
    check_out("post_reset_adv", 2'd1, 4'hB, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
